// File: rtl/key_gen_dec.sv
// DES key schedule generator with encrypt/decrypt ordering and valid/ready
// handshake. Produces the 16 round keys one at a time from a registered C/D
// state; round_key is PC-2 of the registered C/D, so it has no combinational
// path from KEY or start.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request a schedule (sampled in IDLE only)
//   mode         1 = decrypt order K16..K1, 0 = encrypt order K1..K16
//   KEY          64-bit DES key, DES bit 1 = KEY[63], parity bits ignored
//   rk_ready     consumer accepts the presented round key
//   round_key    48-bit round key, DES bit 1 = round_key[47]
//   rk_valid     round_key / rk_index valid
//   rk_index     round number minus 1 of the presented key
//   busy         schedule in progress (EMIT or DONE)
//   done         one-cycle pulse after the final key is accepted
module key_gen_dec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic [63:0] KEY,
  input  logic        rk_ready,
  output logic [47:0] round_key,
  output logic        rk_valid,
  output logic [3:0]  rk_index,
  output logic        busy,
  output logic        done
);

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned CD_W   = 56;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned RK_W   = 48;

  // Bit i set when round i+1 rotates by two positions (otherwise one).
  localparam logic [15:0] SHIFT_TWO = 16'h7EFC;

  localparam int unsigned PC1_TBL [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [RK_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // DES bit n lives at vector position (width - n).
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CD_W); i++) begin
      r[6'(int'(CD_W) - 1 - i)] = k[6'(int'(KEY_W) - int'(PC1_TBL[i]))];
    end
    return r;
  endfunction

  function automatic logic [RK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [RK_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(RK_W); i++) begin
      r[6'(int'(RK_W) - 1 - i)] = cd[6'(int'(CD_W) - int'(PC2_TBL[i]))];
    end
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rol28(input logic [HALF_W-1:0] x,
                                             input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [HALF_W-1:0] ror28(input logic [HALF_W-1:0] x,
                                             input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t             state, state_nxt;
  logic [HALF_W-1:0]  c_q, d_q;
  logic [3:0]         cnt_q;
  logic               mode_q;

  logic [CD_W-1:0]    pc1_key_c;
  logic               hs_c;
  logic               last_c;
  logic               enc_two_c;
  logic               dec_two_c;
  logic               unused_parity_c;

  assign pc1_key_c = pc1(KEY);
  assign hs_c      = (state == S_EMIT) && rk_ready;
  assign last_c    = mode_q ? (cnt_q == 4'd0) : (cnt_q == 4'd15);
  // Encrypt from K_i uses s[i+1]; decrypt from K_i undoes s[i].
  assign enc_two_c = SHIFT_TWO[4'(cnt_q + 4'd1)];
  assign dec_two_c = SHIFT_TWO[cnt_q];

  // Parity bits of KEY are architecturally ignored.
  assign unused_parity_c = ^{KEY[56], KEY[48], KEY[40], KEY[32],
                             KEY[24], KEY[16], KEY[8],  KEY[0]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)           state_nxt = S_EMIT;
      S_EMIT:  if (hs_c && last_c)  state_nxt = S_DONE;
      S_DONE:                       state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    rk_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_EMIT: begin
        rk_valid = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // C/D halves, round counter and latched mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      mode_q <= mode;
      // Unrotated PC-1 equals C16/D16 (total rotation is 28), so decrypt starts there.
      if (mode) begin
        c_q   <= pc1_key_c[55:28];
        d_q   <= pc1_key_c[27:0];
        cnt_q <= 4'd15;
      end else begin
        c_q   <= rol28(pc1_key_c[55:28], 1'b0);
        d_q   <= rol28(pc1_key_c[27:0], 1'b0);
        cnt_q <= 4'd0;
      end
    end else if (hs_c && !last_c) begin
      if (mode_q) begin
        c_q   <= ror28(c_q, dec_two_c);
        d_q   <= ror28(d_q, dec_two_c);
        cnt_q <= 4'(cnt_q - 4'd1);
      end else begin
        c_q   <= rol28(c_q, enc_two_c);
        d_q   <= rol28(d_q, enc_two_c);
        cnt_q <= 4'(cnt_q + 4'd1);
      end
    end
  end

  assign round_key = pc2({c_q, d_q});
  assign rk_index  = cnt_q;

endmodule
